fighter_action_ctrl: RTL
========================

# fighter_action_ctrl

Per-player action sequencer sitting in front of `player_move`. It arbitrates raw button requests (walk, punch, kick, block) against incoming hits and runs a timed attack/hitstun state machine on the game tick `SCEN`. It drives the move requests for `player_move`, so walking is locked out while the fighter is attacking, blocking or stunned. It also exports the hitbox/blocking status consumed by the collision/damage logic.

## Interface
Parameters:
- `CNT_W`, 4: width of the phase counter.
- `PUNCH_STARTUP`, 2; `PUNCH_ACTIVE`, 2; `PUNCH_RECOVERY`, 4: punch phase lengths, in SCEN ticks.
- `KICK_STARTUP`, 4; `KICK_ACTIVE`, 3; `KICK_RECOVERY`, 6: kick phase lengths, in SCEN ticks.
- `HITSTUN`, 8: stun length, in SCEN ticks.
- Every phase length is 1..2^CNT_W-1.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `SCEN` in 1: game-tick enable, one clk wide.
- `btn_left`, `btn_right`, `btn_punch`, `btn_kick`, `btn_block` in 1 each: debounced levels.
- `hit_taken` in 1: one-clk pulse from damage logic; may arrive on any clk.
- `move_left`, `move_right` out 1 each: move requests to `player_move`.
- `hitbox_active` out 1: attack is in its ACTIVE phase.
- `attack_kick` out 1: current or last attack type; 0 = punch, 1 = kick.
- `blocking` out 1: fighter is in BLOCK.
- `stunned` out 1: fighter is in HITSTUN.
- `state` out 3: state encoding, for debug/sprite selection.

## Operation
- State, counter and outputs update only on clk edges with `SCEN`=1. The exception is the hit latch, which updates on every clk.
- Hit latch: `hit_taken` sets a sticky `hit_pend`. It is cleared on the next SCEN edge, where it is consumed.
- Punch/kick requests are rising edges, detected against button levels sampled on the previous SCEN tick.
- States:
  - IDLE=0
  - WALK=1
  - STARTUP=2
  - ACTIVE=3
  - RECOVERY=4
  - BLOCK=5
  - HITSTUN=6
- Priority at each tick, applied in IDLE, WALK and BLOCK:
  1. `hit_pend`, which goes to HITSTUN unless the fighter is in BLOCK.
  2. `btn_block` → BLOCK.
  3. Punch edge → STARTUP, with `attack_kick`=0.
  4. Kick edge → STARTUP, with `attack_kick`=1.
  5. Exactly one of left/right held → WALK.
  6. Otherwise → IDLE.
- Simultaneous punch and kick edges: punch wins.
- `hit_pend` in STARTUP, ACTIVE or RECOVERY aborts the attack → HITSTUN.
- `hit_pend` in BLOCK: the fighter stays in BLOCK and no stun is applied.
- `hit_pend` in HITSTUN reloads the counter to HITSTUN.
- Phase counter: loaded with the phase length on entry and decremented each tick. At 1, the phase advances: STARTUP→ACTIVE→RECOVERY→IDLE, and HITSTUN→IDLE.
- Leaving RECOVERY or HITSTUN always goes to IDLE. The priority list is evaluated on the following tick.
- BLOCK exits to IDLE on the first tick where `btn_block`=0.
- `move_left`/`move_right` are asserted only in WALK, following the held direction. Both held → IDLE, with no movement.

## Timing
- Reset values:
  - state IDLE, counter 0, `hit_pend` 0, sampled buttons 0.
  - All outputs 0.
- Outputs are registered and change one SCEN tick after the causing input is sampled. `player_move` therefore moves on the tick after WALK is entered.
- A punch from IDLE gives `hitbox_active`=1 for exactly PUNCH_ACTIVE ticks. It starts PUNCH_STARTUP ticks after the STARTUP entry tick.
- Total punch occupancy is STARTUP+ACTIVE+RECOVERY ticks; the same holds for a kick with its own lengths.
- A `hit_taken` pulse between ticks is never lost. Multiple pulses between two ticks count as one hit.
- `hit_taken` coincident with `SCEN` is consumed on that same edge.
- `reset_n` low mid-attack returns everything to reset values immediately and asynchronously.

## Configuration
- `INPUT_BUFFER_EN` defined:
  - A punch/kick edge seen during RECOVERY is stored in a one-entry buffer, holding the type; a later edge overwrites it.
  - At RECOVERY exit, the buffered attack goes straight to STARTUP instead of IDLE.
  - The buffer is cleared on use, on HITSTUN entry and on reset.
- Undefined: edges during STARTUP, ACTIVE, RECOVERY and HITSTUN are discarded.

## Structure
- Shared package `fighter_pkg`:
  - state encoding localparams.
  - default phase-length constants, shared with the animation and damage blocks.
- Natural sub-module: `phase_timer` (load, decrement on enable, `done` at count 1). One instance serves all timed states.

## Test plan
- Reset, then `btn_right` held for 3 ticks → WALK on tick 1; `move_right`=1 for ticks 2–4; both move outputs 0 after release.
- Punch edge from IDLE, defaults → STARTUP for 2 ticks, `hitbox_active` high for 2 ticks, RECOVERY for 4 ticks, IDLE on tick 9.
- Kick edge at the start of the ACTIVE phase, with `hit_taken` pulsed between ticks → HITSTUN on the next tick, `hitbox_active` drops, `stunned` high for 8 ticks.
- `btn_block` held plus `hit_taken` → `blocking` stays 1 and `stunned` stays 0. Second hit 3 ticks into HITSTUN → stun ends 8 ticks after the second hit.
- Punch and kick edges on the same tick → punch sequence (`attack_kick`=0). `reset_n` low mid-ACTIVE → all outputs 0 immediately.
- With `INPUT_BUFFER_EN`, kick edge in punch RECOVERY → STARTUP with `attack_kick`=1 immediately after recovery. Without it → IDLE, and the kick is ignored.

Source files
------------

// File: rtl/fighter_pkg.sv
// ---------------------------------------------------------------------------
// fighter_pkg
// Shared definitions for the fighter action path: the 3-bit action-state
// encoding (also used for sprite selection) and the default phase lengths,
// which the animation and damage blocks read as well.
// ---------------------------------------------------------------------------
package fighter_pkg;

    // Action-state encoding.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WALK     = 3'd1;
    localparam logic [2:0] ST_STARTUP  = 3'd2;
    localparam logic [2:0] ST_ACTIVE   = 3'd3;
    localparam logic [2:0] ST_RECOVERY = 3'd4;
    localparam logic [2:0] ST_BLOCK    = 3'd5;
    localparam logic [2:0] ST_HITSTUN  = 3'd6;

    // Default phase lengths, in game ticks.
    localparam int DEF_CNT_W          = 4;
    localparam int DEF_PUNCH_STARTUP  = 2;
    localparam int DEF_PUNCH_ACTIVE   = 2;
    localparam int DEF_PUNCH_RECOVERY = 4;
    localparam int DEF_KICK_STARTUP   = 4;
    localparam int DEF_KICK_ACTIVE    = 3;
    localparam int DEF_KICK_RECOVERY  = 6;
    localparam int DEF_HITSTUN        = 8;

endpackage

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Down-counter shared by every timed action state. It loads a phase length
// and counts down once per enabled tick. o_done flags the last tick of the
// phase, which is when the count reads 1.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_en           game-tick enable
//   i_load         load i_load_val on this tick (takes priority)
//   i_load_val     phase length to load
//   o_done         count == 1, so the phase ends on this tick
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values and evaluation order between blocks cannot matter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_done = (r_count == CNT_W'(1));

endmodule

// File: rtl/fighter_action_ctrl.sv
// ---------------------------------------------------------------------------
// fighter_action_ctrl
// Per-player action sequencer in front of player_move. It arbitrates
// walk/punch/kick/block requests against incoming hits and runs the timed
// attack (STARTUP -> ACTIVE -> RECOVERY) and HITSTUN phases on the game tick
// SCEN. Walking is only requested in WALK, so it is locked out while the
// fighter is attacking, blocking or stunned.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   SCEN                  game-tick enable, one clk wide
//   btn_left/right/punch/kick/block   debounced button levels
//   hit_taken             one-clk hit pulse from the damage logic, any clk
//   move_left/move_right  move requests to player_move
//   hitbox_active         attack is in its ACTIVE phase
//   attack_kick           current/last attack type (0 punch, 1 kick)
//   blocking, stunned     fighter is in BLOCK / HITSTUN
//   state                 action-state encoding (fighter_pkg)
//
// Build option: define INPUT_BUFFER_EN to keep a one-entry attack buffer
// that is filled during RECOVERY and fires as soon as RECOVERY ends.
// ---------------------------------------------------------------------------
module fighter_action_ctrl
    import fighter_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int PUNCH_STARTUP  = DEF_PUNCH_STARTUP,
    parameter int PUNCH_ACTIVE   = DEF_PUNCH_ACTIVE,
    parameter int PUNCH_RECOVERY = DEF_PUNCH_RECOVERY,
    parameter int KICK_STARTUP   = DEF_KICK_STARTUP,
    parameter int KICK_ACTIVE    = DEF_KICK_ACTIVE,
    parameter int KICK_RECOVERY  = DEF_KICK_RECOVERY,
    parameter int HITSTUN        = DEF_HITSTUN
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       SCEN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       btn_block,
    input  logic       hit_taken,
    output logic       move_left,
    output logic       move_right,
    output logic       hitbox_active,
    output logic       attack_kick,
    output logic       blocking,
    output logic       stunned,
    output logic [2:0] state
);

    logic [2:0] r_state;
    logic       r_hit_pend;
    logic       r_left_q, r_right_q, r_punch_q, r_kick_q;
    logic       r_move_left, r_move_right, r_hitbox, r_attack_kick;
    logic       r_blocking, r_stunned;

    logic [2:0]       w_next_state;
    logic             w_next_kick;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_timer_done;
    logic             w_hit;
    logic             w_punch_edge, w_kick_edge;

    function automatic logic [CNT_W-1:0] phase_len(input logic [2:0] st, input logic kick);
        int len;
        case (st)
            ST_STARTUP:  len = kick ? KICK_STARTUP  : PUNCH_STARTUP;
            ST_ACTIVE:   len = kick ? KICK_ACTIVE   : PUNCH_ACTIVE;
            ST_RECOVERY: len = kick ? KICK_RECOVERY : PUNCH_RECOVERY;
            ST_HITSTUN:  len = HITSTUN;
            default:     len = 0;
        endcase
        return CNT_W'(len);
    endfunction

    // A hit arriving on the tick clk itself is consumed on that same edge.
    assign w_hit        = r_hit_pend | hit_taken;
    assign w_punch_edge = btn_punch & ~r_punch_q;
    assign w_kick_edge  = btn_kick  & ~r_kick_q;

`ifdef INPUT_BUFFER_EN
    logic r_buf_valid, r_buf_kick;
    logic w_buf_valid, w_buf_kick;

    // An edge on this very tick overwrites what is stored; punch wins a tie.
    assign w_buf_valid = r_buf_valid | w_punch_edge | w_kick_edge;
    assign w_buf_kick  = (w_punch_edge | w_kick_edge) ? ~w_punch_edge : r_buf_kick;

    // Only kept while RECOVERY continues; RECOVERY exit either uses it or
    // goes to HITSTUN, both of which empty it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_valid <= 1'b0;
            r_buf_kick  <= 1'b0;
        end else if (SCEN) begin
            r_buf_valid <= (r_state == ST_RECOVERY) && !w_hit && !w_timer_done && w_buf_valid;
            r_buf_kick  <= w_buf_kick;
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_kick  = r_attack_kick;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE, ST_WALK: begin
                if (w_hit) begin
                    w_next_state = ST_HITSTUN;
                    w_load       = 1'b1;
                end else if (btn_block) begin
                    w_next_state = ST_BLOCK;
                end else if (w_punch_edge || w_kick_edge) begin
                    w_next_state = ST_STARTUP;
                    w_next_kick  = ~w_punch_edge;
                    w_load       = 1'b1;
                end else if (btn_left ^ btn_right) begin
                    w_next_state = ST_WALK;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            // Hits are absorbed while blocking.
            ST_BLOCK: w_next_state = btn_block ? ST_BLOCK : ST_IDLE;
            ST_STARTUP, ST_ACTIVE, ST_RECOVERY, ST_HITSTUN: begin
                if (w_hit) begin
                    w_next_state = ST_HITSTUN;
                    w_load       = 1'b1;
                end else if (w_timer_done) begin
                    w_load = 1'b1;
                    case (r_state)
                        ST_STARTUP: w_next_state = ST_ACTIVE;
                        ST_ACTIVE:  w_next_state = ST_RECOVERY;
`ifdef INPUT_BUFFER_EN
                        ST_RECOVERY: begin
                            if (w_buf_valid) begin
                                w_next_state = ST_STARTUP;
                                w_next_kick  = w_buf_kick;
                            end else begin
                                w_next_state = ST_IDLE;
                                w_load       = 1'b0;
                            end
                        end
`endif
                        default: begin
                            w_next_state = ST_IDLE;
                            w_load       = 1'b0;
                        end
                    endcase
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        w_load_val = phase_len(w_next_state, w_next_kick);
    end

    phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (SCEN),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_timer_done)
    );

    // Hit latch runs on every clk so pulses between ticks are never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_pend <= 1'b0;
        end else begin
            r_hit_pend <= SCEN ? 1'b0 : (r_hit_pend | hit_taken);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_left_q      <= 1'b0;
            r_right_q     <= 1'b0;
            r_punch_q     <= 1'b0;
            r_kick_q      <= 1'b0;
            r_move_left   <= 1'b0;
            r_move_right  <= 1'b0;
            r_hitbox      <= 1'b0;
            r_attack_kick <= 1'b0;
            r_blocking    <= 1'b0;
            r_stunned     <= 1'b0;
        end else if (SCEN) begin
            r_state       <= w_next_state;
            r_left_q      <= btn_left;
            r_right_q     <= btn_right;
            r_punch_q     <= btn_punch;
            r_kick_q      <= btn_kick;
            // Movement follows WALK one tick later, in the direction that
            // was held when WALK was chosen.
            r_move_left   <= (r_state == ST_WALK) & r_left_q;
            r_move_right  <= (r_state == ST_WALK) & r_right_q;
            r_hitbox      <= (w_next_state == ST_ACTIVE);
            r_attack_kick <= w_next_kick;
            r_blocking    <= (w_next_state == ST_BLOCK);
            r_stunned     <= (w_next_state == ST_HITSTUN);
        end
    end

    assign move_left     = r_move_left;
    assign move_right    = r_move_right;
    assign hitbox_active = r_hitbox;
    assign attack_kick   = r_attack_kick;
    assign blocking      = r_blocking;
    assign stunned       = r_stunned;
    assign state         = r_state;

endmodule
